reflet_timer: RTL and testbench

Memory-mapped timer peripheral acting as a bus responder to reflet_cpu. Decodes CPU addr/write_en/data_out, returns register contents on the CPU data_in path with the same one-cycle registered read latency as the ROM, and raises a level interrupt line intended for one bit of the CPU interrupt_request. Output data is zero when not selected, so it can be OR-ed with other responders.

---
 rtl/reflet_timer.sv | 196 +++++++++++++++++++
 tb/tb_reflet_timer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_timer.sv
// reflet_timer: memory-mapped timer responder for reflet_cpu.
// Five word-aligned registers starting at base_addr: CTRL, PRESCALE,
// COMPARE, COUNT, STATUS. Reads are registered (one-cycle latency, like
// the ROM) and return zero when the responder is not addressed, so the
// read bus can be OR-ed with other responders. The interrupt is a level
// signal derived directly from the match flag and CTRL.irq_en.
//
// Bus protocol: there is no valid/ready handshake. A transfer is offered
// whenever enable is high and addr hits one of the five register
// addresses; the responder is always ready. A write takes effect on the
// edge where the transfer is offered with write_en high. Read data for
// the address presented in cycle N is on data_out during cycle N+1.
// With enable low, or with a misaligned/unmapped address, nothing is
// written and data_out is zero on the following cycle.
module reflet_timer #(
   parameter int                    wordsize  = 16,
   parameter logic [wordsize-1:0]   base_addr = 'hFF00
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [wordsize-1:0] addr,
   input  logic [wordsize-1:0] data_in,
   input  logic                write_en,
   output logic [wordsize-1:0] data_out,
   output logic                interrupt
);

   localparam int BYTES = wordsize / 8;

   // Byte offsets of each register relative to base_addr.
   localparam logic [wordsize-1:0] OFF_CTRL     = wordsize'(0 * BYTES);
   localparam logic [wordsize-1:0] OFF_PRESCALE = wordsize'(1 * BYTES);
   localparam logic [wordsize-1:0] OFF_COMPARE  = wordsize'(2 * BYTES);
   localparam logic [wordsize-1:0] OFF_COUNT    = wordsize'(3 * BYTES);
   localparam logic [wordsize-1:0] OFF_STATUS   = wordsize'(4 * BYTES);

   // CTRL bit positions.
   localparam int CTRL_RUN  = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_IRQ  = 2;

   // Architectural state.
   logic [2:0]          ctrl_q,     ctrl_d;
   logic [wordsize-1:0] prescale_q, prescale_d;
   logic [wordsize-1:0] compare_q,  compare_d;
   logic [wordsize-1:0] count_q,    count_d;
   logic [wordsize-1:0] pcnt_q,     pcnt_d;
   logic                flag_q,     flag_d;
   logic [wordsize-1:0] data_out_q, data_out_d;

   // Address decode and event signals.
   logic [wordsize-1:0] offset;
   logic                hit_ctrl;
   logic                hit_prescale;
   logic                hit_compare;
   logic                hit_count;
   logic                hit_status;
   logic                sel;
   logic                wr_ctrl;
   logic                wr_prescale;
   logic                wr_compare;
   logic                wr_count;
   logic                wr_status;
   logic                run;
   logic                tick;
   logic                match;

   // Decode: an exact offset match implies both alignment and range.
   always_comb begin
      offset       = addr - base_addr;
      hit_ctrl     = enable && (offset == OFF_CTRL);
      hit_prescale = enable && (offset == OFF_PRESCALE);
      hit_compare  = enable && (offset == OFF_COMPARE);
      hit_count    = enable && (offset == OFF_COUNT);
      hit_status   = enable && (offset == OFF_STATUS);
      sel          = hit_ctrl | hit_prescale | hit_compare | hit_count | hit_status;
      wr_ctrl      = hit_ctrl     && write_en;
      wr_prescale  = hit_prescale && write_en;
      wr_compare   = hit_compare  && write_en;
      wr_count     = hit_count    && write_en;
      wr_status    = hit_status   && write_en;
   end

   // Prescaler tick and compare-match detection for the current cycle.
   always_comb begin
      run   = ctrl_q[CTRL_RUN];
      tick  = run && (pcnt_q == prescale_q);
      match = tick && (count_q == compare_q);
   end

   // Prescale counter: restarts on a PRESCALE write, wraps on tick, holds when stopped.
   always_comb begin
      pcnt_d = pcnt_q;
      if (wr_prescale) begin
         pcnt_d = '0;
      end else if (run) begin
         if (tick) begin
            pcnt_d = '0;
         end else begin
            pcnt_d = pcnt_q + 1'b1;
         end
      end
   end

   // CTRL: software write beats the one-shot run clear on the same edge.
   always_comb begin
      ctrl_d = ctrl_q;
      if (wr_ctrl) begin
         ctrl_d = data_in[2:0];
      end else if (match && !ctrl_q[CTRL_AUTO]) begin
         ctrl_d[CTRL_RUN] = 1'b0;
      end
   end

   // PRESCALE and COMPARE are plain software-loaded registers.
   always_comb begin
      prescale_d = prescale_q;
      compare_d  = compare_q;
      if (wr_prescale) begin
         prescale_d = data_in;
      end
      if (wr_compare) begin
         compare_d = data_in;
      end
   end

   // COUNT: software write beats tick; on match reload to 0 or hold (one-shot).
   always_comb begin
      count_d = count_q;
      if (wr_count) begin
         count_d = data_in;
      end else if (tick) begin
         if (match) begin
            if (ctrl_q[CTRL_AUTO]) begin
               count_d = '0;
            end
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // STATUS flag: a match sets it even if software clears it on the same edge.
   always_comb begin
      flag_d = flag_q;
      if (match) begin
         flag_d = 1'b1;
      end else if (wr_status && data_in[0]) begin
         flag_d = 1'b0;
      end
   end

   // Registered read mux; unselected reads return zero for OR-ing.
   always_comb begin
      data_out_d = '0;
      if (sel) begin
         if (hit_ctrl) begin
            data_out_d = {{(wordsize-3){1'b0}}, ctrl_q};
         end else if (hit_prescale) begin
            data_out_d = prescale_q;
         end else if (hit_compare) begin
            data_out_d = compare_q;
         end else if (hit_count) begin
            data_out_d = count_q;
         end else begin
            data_out_d = {{(wordsize-1){1'b0}}, flag_q};
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q     <= '0;
         prescale_q <= '0;
         compare_q  <= '0;
         count_q    <= '0;
         pcnt_q     <= '0;
         flag_q     <= 1'b0;
         data_out_q <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         compare_q  <= compare_d;
         count_q    <= count_d;
         pcnt_q     <= pcnt_d;
         flag_q     <= flag_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out  = data_out_q;
   assign interrupt = flag_q && ctrl_q[CTRL_IRQ];

endmodule

// File: tb/tb_reflet_timer.sv
// Testbench for reflet_timer: directed scenarios plus randomized
// auto-reload runs. Read responses are checked by a scoreboard monitor
// against values pushed when each read is issued; timer values come from
// a closed-form model (ticks = n/(P+1), count = ticks mod (C+1)).
module tb_reflet_timer;

   localparam int W = 16;
   localparam logic [W-1:0] BASE   = 16'hFF00;
   localparam logic [W-1:0] A_CTRL = BASE;
   localparam logic [W-1:0] A_PRE  = BASE + 16'd2;
   localparam logic [W-1:0] A_CMP  = BASE + 16'd4;
   localparam logic [W-1:0] A_CNT  = BASE + 16'd6;
   localparam logic [W-1:0] A_STAT = BASE + 16'd8;

   logic         clk      = 1'b0;
   logic         reset    = 1'b0;
   logic         enable   = 1'b0;
   logic         write_en = 1'b0;
   logic [W-1:0] addr     = '0;
   logic [W-1:0] data_in  = '0;
   logic [W-1:0] data_out;
   logic         interrupt;

   reflet_timer #(.wordsize(W), .base_addr(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .addr      (addr),
      .data_in   (data_in),
      .write_en  (write_en),
      .data_out  (data_out),
      .interrupt (interrupt)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   logic         rd_tag = 1'b0;
   int           checks = 0;
   int           passes = 0;
   int unsigned  t_run  = 0;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %b expected %b", nm, act, exp);
   endtask

   // Monitor: a read offered before a rising edge is answered just after it.
   initial begin : monitor
      logic [W-1:0] e;
      string        nm;
      forever begin
         @(posedge clk);
         if (rd_tag) begin
            #1;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL monitor_underflow: got %h expected no read", data_out);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               check(nm, data_out, e);
            end
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] m_count(input int unsigned n, input int unsigned p,
                                            input int unsigned c);
      return W'((n / (p + 1)) % (c + 1));
   endfunction

   function automatic logic m_flag(input int unsigned n, input int unsigned p,
                                   input int unsigned c);
      return ((n / (p + 1)) / (c + 1)) != 0;
   endfunction

   // ---------------- driver tasks (called at a falling edge) ----------------
   task automatic idle();
      enable   = 1'b0;
      write_en = 1'b0;
      addr     = '0;
      data_in  = '0;
   endtask

   task automatic bus_write(input logic [W-1:0] a, input logic [W-1:0] d, input logic en = 1'b1);
      enable   = en;
      write_en = 1'b1;
      addr     = a;
      data_in  = d;
      @(negedge clk);
      idle();
   endtask

   task automatic bus_read(input logic [W-1:0] a, input logic [W-1:0] e, input string nm,
                           input logic en = 1'b1);
      enable   = en;
      write_en = 1'b0;
      addr     = a;
      exp_q.push_back(e);
      name_q.push_back(nm);
      rd_tag   = 1'b1;
      @(negedge clk);
      rd_tag   = 1'b0;
      idle();
   endtask

   // Stop, configure, clear flag; timer stays stopped.
   task automatic setup(input logic [W-1:0] p, input logic [W-1:0] c, input logic [W-1:0] cnt);
      bus_write(A_CTRL, '0);
      bus_write(A_PRE, p);
      bus_write(A_CMP, c);
      bus_write(A_CNT, cnt);
      bus_write(A_STAT, 16'd1);
   endtask

   // CTRL write; t_run is the edge it commits on. On return n = 0.
   task automatic start_run(input logic [W-1:0] ctrl_val);
      t_run = cyc + 1;
      bus_write(A_CTRL, ctrl_val);
   endtask

   // Advance to the falling edge where state reflects n edges after t_run.
   task automatic wait_n(input int unsigned n);
      int guard = 0;
      while (cyc < t_run + n && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != t_run + n) begin
         checks++;
         $display("FAIL wait_n: got n=%0d expected n=%0d", cyc - t_run, n);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      int unsigned p, c, n;
      logic        irq;

      // Reset / readback
      idle();
      reset = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check("rst_data_out", data_out, '0);
      check1("rst_irq", interrupt, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bus_read(A_CTRL, '0, "rst_ctrl");
      bus_read(A_PRE,  '0, "rst_pre");
      bus_read(A_CMP,  '0, "rst_cmp");
      bus_read(A_CNT,  '0, "rst_cnt");
      bus_read(A_STAT, '0, "rst_stat");
      bus_write(A_PRE, 16'd3);
      bus_write(A_CMP, 16'd5);
      bus_read(A_PRE, 16'd3, "rb_pre");
      bus_read(A_CMP, 16'd5, "rb_cmp");
      bus_read(BASE + 16'd10, '0, "rd_unmapped");
      bus_read(BASE + 16'd1,  '0, "rd_misaligned");
      bus_read(A_CMP, '0, "rd_enable_low", 1'b0);
      bus_write(A_CMP, 16'd77, 1'b0);
      bus_read(A_CMP, 16'd5, "wr_enable_low");

      // One-shot: flag/interrupt rise exactly 5 edges after the CTRL write
      setup(16'd0, 16'd4, 16'd0);
      start_run(16'd5);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check1("oneshot_irq_timing", interrupt, k >= 5);
      end
      bus_read(A_CNT,  16'd4, "oneshot_count");
      bus_read(A_CTRL, 16'd4, "oneshot_ctrl");
      bus_read(A_STAT, 16'd1, "oneshot_flag");
      bus_write(A_STAT, 16'd1);
      bus_read(A_STAT, 16'd0, "w1c_clear");
      check1("w1c_irq_low", interrupt, 1'b0);

      // Auto-reload with prescale 2, compare 2, irq disabled
      setup(16'd2, 16'd2, 16'd0);
      start_run(16'd3);
      wait_n(2);
      bus_read(A_CNT, m_count(2, 2, 2), "auto_cnt_n2");
      bus_read(A_CNT, m_count(3, 2, 2), "auto_cnt_n3");
      wait_n(5);
      bus_read(A_CNT, m_count(5, 2, 2), "auto_cnt_n5");
      bus_read(A_CNT, m_count(6, 2, 2), "auto_cnt_n6");
      wait_n(8);
      bus_read(A_STAT, W'(m_flag(8, 2, 2)), "auto_flag_n8");
      bus_read(A_STAT, W'(m_flag(9, 2, 2)), "auto_flag_n9");
      check1("auto_irq_disabled", interrupt, 1'b0);
      bus_read(A_CNT, m_count(10, 2, 2), "auto_cnt_n10");
      bus_write(A_STAT, 16'd1);
      bus_read(A_STAT, 16'd0, "auto_w1c");
      // COUNT write lands on the tick edge n=15
      wait_n(14);
      bus_write(A_CNT, 16'd100);
      bus_read(A_CNT, 16'd100, "coll_count_write");

      // W1C on the match edge: set wins
      setup(16'd0, 16'd3, 16'd0);
      start_run(16'd3);
      wait_n(3);
      bus_write(A_STAT, 16'd1);
      bus_read(A_STAT, 16'd1, "coll_w1c_match");

      // CTRL write on the one-shot clear edge: write wins
      setup(16'd0, 16'd2, 16'd0);
      start_run(16'd1);
      wait_n(2);
      bus_write(A_CTRL, 16'd5);
      bus_read(A_CTRL, 16'd5, "coll_ctrl_write");
      bus_read(A_CTRL, 16'd4, "coll_ctrl_later");
      bus_read(A_CNT,  16'd2, "coll_cnt_hold");
      check1("coll_irq", interrupt, 1'b1);

      // Wrap FFFF -> 0 without flag, then match at 2
      setup(16'd0, 16'd2, 16'hFFFF);
      start_run(16'd1);
      wait_n(1);
      bus_read(A_CNT,  16'd0, "wrap_cnt0");
      bus_read(A_CNT,  16'd1, "wrap_cnt1");
      bus_read(A_STAT, 16'd0, "wrap_no_flag");
      bus_read(A_CNT,  16'd2, "wrap_cnt2");
      bus_read(A_STAT, 16'd1, "wrap_flag");

      // Randomized auto-reload runs against the closed-form model
      for (int it = 0; it < 6; it++) begin
         p   = $urandom_range(0, 3);
         c   = $urandom_range(0, 5);
         irq = 1'($urandom_range(0, 1));
         setup(W'(p), W'(c), '0);
         start_run({13'd0, irq, 2'b11});
         n = $urandom_range(1, 4);
         for (int r = 0; r < 4; r++) begin
            wait_n(n);
            check1("rand_irq", interrupt, irq && m_flag(n, p, c));
            bus_read(A_CNT,  m_count(n, p, c), "rand_count");
            bus_read(A_STAT, W'(m_flag(n + 1, p, c)), "rand_flag");
            n = n + $urandom_range(2, 9);
         end
      end

      // Reset mid-count: interrupt drops immediately, everything clears
      setup(16'd0, 16'd0, 16'd0);
      start_run(16'd7);
      wait_n(3);
      check1("pre_reset_irq", interrupt, 1'b1);
      reset = 1'b0;
      #1;
      check1("async_reset_irq", interrupt, 1'b0);
      check("async_reset_data", data_out, '0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bus_read(A_CTRL, '0, "post_rst_ctrl");
      bus_read(A_PRE,  '0, "post_rst_pre");
      bus_read(A_CMP,  '0, "post_rst_cmp");
      bus_read(A_CNT,  '0, "post_rst_cnt");
      bus_read(A_STAT, '0, "post_rst_stat");
      repeat (5) @(negedge clk);
      bus_read(A_CNT, '0, "post_rst_idle_cnt");
      check1("post_rst_irq", interrupt, 1'b0);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
